// File: rtl/median_filt_ctrl_pkg.sv
// rtl/median_filt_ctrl_pkg.sv - shared types and constants for the median filter controller
package median_filt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECK    = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  localparam int CNT_W   = 12;
  localparam int MATCH_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 12'd4095;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/median_filt_ctrl_vid_timing_meas.sv
// rtl/median_filt_ctrl_vid_timing_meas.sv - frame boundary detect and per-frame line/pixel measurement
module vid_timing_meas
  import median_filt_ctrl_pkg::*;
#(
  parameter bit SYNC_POL = 1'b1
) (
  input  logic             rx_clk,
  input  logic             rstn,
  input  logic             rx_dv,
  input  logic             rx_vs,
  output logic             fb,
  output logic [CNT_W-1:0] cand_h,
  output logic [CNT_W-1:0] cand_v,
  output logic             frame_bad
);

  logic             vs_act, vs_d, dv_d, dv_fall;
  logic [CNT_W-1:0] pix_cnt, line_cnt, ref_len;
  logic [CNT_W-1:0] line_cnt_nx, ref_len_nx;
  logic             bad, bad_nx;

  assign vs_act  = (rx_vs == SYNC_POL);
  assign fb      = vs_act & ~vs_d;
  assign dv_fall = dv_d & ~rx_dv;

  // Next-state view of the frame so a line ending on the fb cycle still counts.
  always_comb begin
    line_cnt_nx = line_cnt;
    ref_len_nx  = ref_len;
    bad_nx      = bad;
    if (rx_dv && pix_cnt == CNT_MAX) bad_nx = 1'b1;
    if (dv_fall) begin
      line_cnt_nx = sat_inc(line_cnt);
      if (line_cnt == CNT_MAX) bad_nx = 1'b1;
      if (line_cnt == '0) ref_len_nx = pix_cnt;
      else if (pix_cnt != ref_len) bad_nx = 1'b1;
    end
  end

  assign cand_h    = ref_len_nx;
  assign cand_v    = line_cnt_nx;
  assign frame_bad = bad_nx | (line_cnt_nx == '0);

  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn) begin
      vs_d     <= 1'b0;
      dv_d     <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      ref_len  <= '0;
      bad      <= 1'b0;
    end else begin
      vs_d <= vs_act;
      dv_d <= rx_dv;
      if (fb) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
        ref_len  <= '0;
        bad      <= 1'b0;
      end else begin
        line_cnt <= line_cnt_nx;
        ref_len  <= ref_len_nx;
        bad      <= bad_nx;
        if (dv_fall) pix_cnt <= '0;
        else if (rx_dv) pix_cnt <= sat_inc(pix_cnt);
      end
    end
  end

endmodule

// File: rtl/median_filt_ctrl.sv
// rtl/median_filt_ctrl.sv - timing lock, filter core control and frame-aligned TX source select
// MODE_SWITCH_BLANK_EN: blank TX RGB for one frame after every mode_act change.
module median_filt_ctrl
  import median_filt_ctrl_pkg::*;
#(
  parameter int LOCK_FRAMES = 4,
  parameter int TIMEOUT_CYC = 4194304,
  parameter bit SYNC_POL    = 1'b1
) (
  input  logic             rx_clk,
  input  logic             rstn,
  input  logic [7:0]       rx_red,
  input  logic [7:0]       rx_green,
  input  logic [7:0]       rx_blue,
  input  logic             rx_dv,
  input  logic             rx_hs,
  input  logic             rx_vs,
  input  logic [7:0]       filt_red,
  input  logic [7:0]       filt_green,
  input  logic [7:0]       filt_blue,
  input  logic             filt_dv,
  input  logic             filt_hs,
  input  logic             filt_vs,
  output logic             filt_rst,
  output logic             filt_start,
  input  logic             mode_req,
  output logic [7:0]       tx_red,
  output logic [7:0]       tx_green,
  output logic [7:0]       tx_blue,
  output logic             tx_dv,
  output logic             tx_hs,
  output logic             tx_vs,
  output logic             mode_act,
  output logic             locked,
  output logic             lock_lost,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [MATCH_W-1:0] LOCK_N  = MATCH_W'(LOCK_FRAMES);

  logic               fb, frame_bad, cand_match, timeout;
  logic [CNT_W-1:0]   cand_h, cand_v, st_h, st_v, st_h_nx, st_v_nx;
  logic [MATCH_W-1:0] match_cnt, match_nx;
  logic [TO_W-1:0]    to_cnt;
  logic               mode_nx, lost_nx, blank;
  lock_state_t        state, state_nx;
  logic [7:0]         src_red, src_green, src_blue;
  logic               src_dv, src_hs, src_vs;

  vid_timing_meas #(.SYNC_POL(SYNC_POL)) u_meas (
    .rx_clk    (rx_clk),
    .rstn      (rstn),
    .rx_dv     (rx_dv),
    .rx_vs     (rx_vs),
    .fb        (fb),
    .cand_h    (cand_h),
    .cand_v    (cand_v),
    .frame_bad (frame_bad)
  );

  assign cand_match = (cand_h == st_h) && (cand_v == st_v);
  assign timeout    = ~fb && (to_cnt == TO_LAST);
  assign locked     = (state == ST_LOCKED);

  always_comb begin
    state_nx = state;
    match_nx = match_cnt;
    st_h_nx  = st_h;
    st_v_nx  = st_v;
    mode_nx  = mode_act;
    lost_nx  = 1'b0;
    if (timeout) begin
      state_nx = ST_UNLOCKED;
      mode_nx  = 1'b0;
      lost_nx  = (state == ST_LOCKED);
    end else if (fb) begin
      case (state)
        ST_UNLOCKED: if (!frame_bad) begin
          state_nx = ST_CHECK;
          match_nx = MATCH_W'(1);
          st_h_nx  = cand_h;
          st_v_nx  = cand_v;
        end
        ST_CHECK: begin
          if (frame_bad) begin
            state_nx = ST_UNLOCKED;
          end else if (cand_match) begin
            match_nx = match_cnt + MATCH_W'(1);
            if (match_nx == LOCK_N) begin
              state_nx = ST_LOCKED;
              mode_nx  = mode_req;
            end
          end else begin
            match_nx = MATCH_W'(1);
            st_h_nx  = cand_h;
            st_v_nx  = cand_v;
          end
        end
        ST_LOCKED: begin
          if (frame_bad || !cand_match) begin
            state_nx = ST_UNLOCKED;
            mode_nx  = 1'b0;
            lost_nx  = 1'b1;
          end else begin
            mode_nx = mode_req;
          end
        end
        default: state_nx = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_UNLOCKED;
      match_cnt  <= '0;
      st_h       <= '0;
      st_v       <= '0;
      h_active   <= '0;
      v_active   <= '0;
      mode_act   <= 1'b0;
      lock_lost  <= 1'b0;
      filt_rst   <= 1'b1;
      filt_start <= 1'b0;
      to_cnt     <= '0;
    end else begin
      state      <= state_nx;
      match_cnt  <= match_nx;
      st_h       <= st_h_nx;
      st_v       <= st_v_nx;
      mode_act   <= mode_nx;
      lock_lost  <= lost_nx;
      filt_rst   <= ~locked;
      filt_start <= locked;
      if (state != ST_LOCKED && state_nx == ST_LOCKED) begin
        h_active <= st_h_nx;
        v_active <= st_v_nx;
      end
      // Saturate so the timeout stays asserted until the next fb.
      if (fb) to_cnt <= '0;
      else if (to_cnt != TO_LAST) to_cnt <= to_cnt + TO_W'(1);
    end
  end

`ifdef MODE_SWITCH_BLANK_EN
  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn) blank <= 1'b0;
    else if (mode_nx != mode_act) blank <= 1'b1;
    else if (fb) blank <= 1'b0;
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    src_red   = rx_red;
    src_green = rx_green;
    src_blue  = rx_blue;
    src_dv    = rx_dv;
    src_hs    = rx_hs;
    src_vs    = rx_vs;
    if (mode_act) begin
      src_red   = filt_red;
      src_green = filt_green;
      src_blue  = filt_blue;
      src_dv    = filt_dv;
      src_hs    = filt_hs;
      src_vs    = filt_vs;
    end
  end

  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn) begin
      tx_red   <= '0;
      tx_green <= '0;
      tx_blue  <= '0;
      tx_dv    <= 1'b0;
      tx_hs    <= 1'b0;
      tx_vs    <= 1'b0;
    end else begin
      tx_red   <= blank ? 8'd0 : src_red;
      tx_green <= blank ? 8'd0 : src_green;
      tx_blue  <= blank ? 8'd0 : src_blue;
      tx_dv    <= src_dv;
      tx_hs    <= src_hs;
      tx_vs    <= src_vs;
    end
  end

endmodule
